// File: rtl/rv_pkg.sv
// Shared rv32 pipeline constants: one-hot opcode bit positions, funct3 codes,
// writeback state encoding and the default datapath width.
package rv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int OPC_W        = 11;

  localparam int OPC_RTYPE  = 0;
  localparam int OPC_ITYPE  = 1;
  localparam int OPC_LOAD   = 2;
  localparam int OPC_STORE  = 3;
  localparam int OPC_BRANCH = 4;
  localparam int OPC_JAL    = 5;
  localparam int OPC_JALR   = 6;
  localparam int OPC_LUI    = 7;
  localparam int OPC_AUIPC  = 8;
  localparam int OPC_SYSTEM = 9;
  localparam int OPC_FENCE  = 10;

  localparam logic [2:0] F3_PRIV   = 3'b000;
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;

  typedef enum logic {
    WB_RUN       = 1'b0,
    WB_LOAD_WAIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/rv_next_pc.sv
// Next-PC selection: one adder feeds auipc, branch, jal and jalr targets; also flags misaligned targets.
// Purely combinational, zero latency; no flow control of its own.
module rv_next_pc
  import rv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int C_EXT = 0
) (
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic             alu_lsb_i,
  input  logic [OPC_W-1:0] opcode_i,
  input  logic             compressed_i,
  input  logic             flush_i,
  input  logic             trap_i,
  input  logic             mret_i,
  input  logic [XLEN-1:0]  trap_addr_i,
  input  logic [XLEN-1:0]  ret_addr_i,
  output logic [XLEN-1:0]  pc_inc_o,
  output logic [XLEN-1:0]  sum_o,
  output logic [XLEN-1:0]  next_pc_o,
  output logic             misaligned_o
);

  logic [XLEN-1:0] inc;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] target;
  logic            taken;

  always_comb begin
    inc      = ((C_EXT != 0) && compressed_i) ? XLEN'(2) : XLEN'(4);
    pc_inc_o = pc_i + inc;
    base     = opcode_i[OPC_JALR] ? rs1_i : pc_i;
    sum_o    = base + imm_i;
    target   = sum_o;
    if (opcode_i[OPC_JALR]) target[0] = 1'b0;
    taken = opcode_i[OPC_JAL] | opcode_i[OPC_JALR] | (opcode_i[OPC_BRANCH] & alu_lsb_i);
    // Without C, only word-aligned targets are legal; bit0 is always clear here.
    misaligned_o = taken && (C_EXT == 0) && target[1];

    if (flush_i)     next_pc_o = pc_i;
    else if (trap_i) next_pc_o = trap_addr_i;
    else if (mret_i) next_pc_o = ret_addr_i;
    else if (taken)  next_pc_o = target;
    else             next_pc_o = pc_inc_o;
  end

endmodule

// File: rtl/rv_writeback_ext.sv
// Writeback/PC-update stage: commits pc, rd and instret; results register one cycle after commit.
// Stalls upstream (o_stall) while a load's data is late; flush wins over everything.
module rv_writeback_ext
  import rv_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] PC_RESET  = '0,
  parameter int              C_EXT     = 0,
  parameter int              INSTRET_W = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_ce,
  output logic                 o_ce,
  output logic                 o_stall,
  input  logic                 i_flush,
  input  logic [2:0]           i_funct3,
  input  logic [XLEN-1:0]      i_alu_out,
  input  logic [XLEN-1:0]      i_imm,
  input  logic [XLEN-1:0]      i_rs1,
  input  logic [XLEN-1:0]      i_data_load,
  input  logic [XLEN-1:0]      i_csr_out,
  input  logic                 i_load_valid,
  input  logic                 i_compressed,
  input  logic [OPC_W-1:0]     i_opcode,
  input  logic                 i_go_to_trap,
  input  logic                 i_return_from_trap,
  input  logic [XLEN-1:0]      i_trap_address,
  input  logic [XLEN-1:0]      i_return_address,
  output logic [XLEN-1:0]      o_rd,
  output logic                 o_wr_rd,
  output logic [XLEN-1:0]      o_next_pc,
  output logic                 o_pc_misaligned,
  output logic [INSTRET_W-1:0] o_instret
);

  wb_state_e            state_q, state_d;
  logic [XLEN-1:0]      pc_q, pc_d;
  logic [XLEN-1:0]      rd_q, rd_d;
  logic                 wr_rd_q, wr_rd_d;
  logic                 ce_q;
  logic                 mis_q;
  logic [INSTRET_W-1:0] instret_q;

  logic [XLEN-1:0] pc_inc, sum;
  logic            misaligned;
  logic            enter_wait;
  logic            fire;
  logic            is_sys_priv;

  rv_next_pc #(.XLEN(XLEN), .C_EXT(C_EXT)) u_next_pc (
    .pc_i        (pc_q),
    .imm_i       (i_imm),
    .rs1_i       (i_rs1),
    .alu_lsb_i   (i_alu_out[0]),
    .opcode_i    (i_opcode),
    .compressed_i(i_compressed),
    .flush_i     (i_flush),
    .trap_i      (i_go_to_trap),
    .mret_i      (i_return_from_trap),
    .trap_addr_i (i_trap_address),
    .ret_addr_i  (i_return_address),
    .pc_inc_o    (pc_inc),
    .sum_o       (sum),
    .next_pc_o   (pc_d),
    .misaligned_o(misaligned)
  );

  assign enter_wait  = i_ce && !i_flush && !i_go_to_trap && !i_return_from_trap
                       && i_opcode[OPC_LOAD] && !i_load_valid;
  assign is_sys_priv = i_opcode[OPC_SYSTEM] && (i_funct3 == F3_PRIV);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= WB_RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_RUN:       if (enter_wait) state_d = WB_LOAD_WAIT;
      WB_LOAD_WAIT: if (i_flush || i_load_valid) state_d = WB_RUN;
      default:      state_d = WB_RUN;
    endcase
  end

  always_comb begin
    o_stall = 1'b0;
    fire    = 1'b0;
    case (state_q)
      WB_RUN: begin
        o_stall = enter_wait;
        fire    = i_ce && !i_flush && !enter_wait;
      end
      WB_LOAD_WAIT: begin
        o_stall = !i_flush && !i_load_valid;
        fire    = !i_flush && i_load_valid;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_d = '0;
    if (i_opcode[OPC_RTYPE] || i_opcode[OPC_ITYPE]) rd_d = i_alu_out;
    else if (i_opcode[OPC_LOAD])                    rd_d = i_data_load;
    else if (i_opcode[OPC_LUI])                     rd_d = i_imm;
    else if (i_opcode[OPC_AUIPC])                   rd_d = sum;
    else if (i_opcode[OPC_JAL] || i_opcode[OPC_JALR]) rd_d = pc_inc;
    else if (i_opcode[OPC_SYSTEM] && !is_sys_priv) rd_d = i_csr_out;
    wr_rd_d = !(i_opcode[OPC_BRANCH] || i_opcode[OPC_STORE] || i_opcode[OPC_FENCE] || is_sys_priv);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc_q      <= PC_RESET;
      rd_q      <= '0;
      wr_rd_q   <= 1'b0;
      ce_q      <= 1'b0;
      mis_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      ce_q  <= 1'b0;
      mis_q <= 1'b0;
      if (fire) begin
        if (i_go_to_trap) begin
          pc_q    <= pc_d;
          wr_rd_q <= 1'b0;
          ce_q    <= 1'b1;
        end else if (i_return_from_trap) begin
          pc_q      <= pc_d;
          wr_rd_q   <= 1'b0;
          ce_q      <= 1'b1;
          instret_q <= instret_q + INSTRET_W'(1);
        end else if (misaligned) begin
          // Nothing commits; the trap unit reads the bad target from o_next_pc.
          mis_q <= 1'b1;
        end else begin
          pc_q      <= pc_d;
          rd_q      <= rd_d;
          wr_rd_q   <= wr_rd_d;
          ce_q      <= 1'b1;
          instret_q <= instret_q + INSTRET_W'(1);
        end
      end
    end
  end

  assign o_ce            = ce_q;
  assign o_rd            = rd_q;
  assign o_wr_rd         = wr_rd_q;
  assign o_next_pc       = pc_d;
  assign o_pc_misaligned = mis_q;
  assign o_instret       = instret_q;

endmodule

// File: tb/tb_rv_writeback_ext.sv
// Bench for rv_writeback_ext: a C_EXT=0 instance scoreboarded on o_ce, plus a C_EXT=1 / 2-bit instret instance.
module tb_rv_writeback_ext;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0, flush = 1'b0, lvalid = 1'b0, comp = 1'b0, trap = 1'b0, mret = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] alu = '0, imm = '0, rs1 = '0, dload = '0, csr = '0, taddr = '0, raddr = '0;
  logic [10:0] opc = 11'b10;

  logic        oce0, stall0, wr0, mis0;
  logic [31:0] rd0, npc0;
  logic [63:0] ir0;
  logic        oce1, stall1, wr1, mis1;
  logic [31:0] rd1, npc1;
  logic [1:0]  ir1;

  typedef struct {logic [31:0] rd; logic wr; logic chk;} exp_t;
  exp_t q[$];

  int total = 0;
  int bad = 0;
  logic [31:0] pc_m;
  logic [63:0] ir_m;

  always #5 clk = ~clk;

  rv_writeback_ext #(.XLEN(32), .PC_RESET(32'h100), .C_EXT(0), .INSTRET_W(64)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .o_ce(oce0), .o_stall(stall0), .i_flush(flush),
    .i_funct3(f3), .i_alu_out(alu), .i_imm(imm), .i_rs1(rs1), .i_data_load(dload), .i_csr_out(csr),
    .i_load_valid(lvalid), .i_compressed(comp), .i_opcode(opc), .i_go_to_trap(trap),
    .i_return_from_trap(mret), .i_trap_address(taddr), .i_return_address(raddr),
    .o_rd(rd0), .o_wr_rd(wr0), .o_next_pc(npc0), .o_pc_misaligned(mis0), .o_instret(ir0));

  rv_writeback_ext #(.XLEN(32), .PC_RESET(32'h100), .C_EXT(1), .INSTRET_W(2)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .o_ce(oce1), .o_stall(stall1), .i_flush(flush),
    .i_funct3(f3), .i_alu_out(alu), .i_imm(imm), .i_rs1(rs1), .i_data_load(dload), .i_csr_out(csr),
    .i_load_valid(lvalid), .i_compressed(comp), .i_opcode(opc), .i_go_to_trap(trap),
    .i_return_from_trap(mret), .i_trap_address(taddr), .i_return_address(raddr),
    .o_rd(rd1), .o_wr_rd(wr1), .o_next_pc(npc1), .o_pc_misaligned(mis1), .o_instret(ir1));

  function automatic logic [10:0] oh(input int i);
    logic [10:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Scoreboard: every o_ce pulse of dut0 retires exactly one pushed expectation.
  always @(negedge clk) begin
    if (rst_n && oce0 === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++; $display("FAIL sb_unexpected_commit got o_ce=1 want no commit");
      end else begin
        exp_t e;
        e = q.pop_front();
        if (oce0 !== 1'b1 || wr0 !== e.wr || (e.chk && rd0 !== e.rd)) begin
          bad++; $display("FAIL sb_commit got rd=%h wr=%b want rd=%h wr=%b", rd0, wr0, e.rd, e.wr);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    ce = 0; flush = 0; trap = 0; mret = 0; lvalid = 0; comp = 0; imm = '0; opc = oh(OPC_ITYPE); f3 = '0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; idle(); step(); step(); rst_n = 1; #1;
    pc_m = 32'h100; ir_m = 0;
    total++; if (npc0 !== 32'h104) begin bad++; $display("FAIL reset_npc got=%h want=%h", npc0, 32'h104); end
    total++; if (ir0 !== 64'd0) begin bad++; $display("FAIL reset_instret got=%0d want=0", ir0); end
    total++; if ({oce0, wr0, mis0, stall0} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {oce0, wr0, mis0, stall0}); end
    total++; if (rd0 !== 32'd0) begin bad++; $display("FAIL reset_rd got=%h want=0", rd0); end
    total++; if (npc1 !== 32'h104) begin bad++; $display("FAIL reset_npc_c got=%h want=%h", npc1, 32'h104); end
  endtask

  task automatic test_jal();
    ce = 1; opc = oh(OPC_JAL); imm = 32'h20; #1;
    total++; if (npc0 !== pc_m + 32'h20) begin bad++; $display("FAIL jal_target got=%h want=%h", npc0, pc_m + 32'h20); end
    q.push_back('{rd: pc_m + 32'd4, wr: 1'b1, chk: 1'b1});
    step(); idle();
    pc_m = pc_m + 32'h20; ir_m++;
    total++; if (npc0 !== pc_m + 32'd4) begin bad++; $display("FAIL jal_pc got=%h want=%h", npc0, pc_m + 32'd4); end
    total++; if (ir0 !== ir_m) begin bad++; $display("FAIL jal_instret got=%0d want=%0d", ir0, ir_m); end
  endtask

  task automatic test_results();
    int          k [11] = '{OPC_RTYPE, OPC_ITYPE, OPC_LUI, OPC_AUIPC, OPC_STORE, OPC_BRANCH, OPC_BRANCH,
                            OPC_SYSTEM, OPC_SYSTEM, OPC_FENCE, OPC_LOAD};
    logic [31:0] a [11] = '{32'h11111111, 32'hA5A5, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    logic [31:0] m [11] = '{0, 0, 32'h12345000, 32'h3000, 0, 32'h40, 32'h40, 0, 0, 0, 0};
    logic [2:0]  f [11] = '{0, 0, 0, 0, 0, 0, 0, 3'd1, 3'd0, 0, 0};
    for (int i = 0; i < 11; i++) begin
      logic [31:0] er, en;
      logic        ew;
      ce = 1; opc = oh(k[i]); alu = a[i]; imm = m[i]; f3 = f[i]; csr = 32'hCAFE0000 + i;
      lvalid = (k[i] == OPC_LOAD); dload = 32'h55AA0000 + i; #1;
      er = 0; ew = 1; en = pc_m + 4;
      case (k[i])
        OPC_RTYPE, OPC_ITYPE: er = a[i];
        OPC_LUI:              er = m[i];
        OPC_AUIPC:            er = pc_m + m[i];
        OPC_STORE, OPC_FENCE: ew = 0;
        OPC_BRANCH: begin ew = 0; if (a[i][0]) en = pc_m + m[i]; end
        OPC_SYSTEM: if (f[i] == 0) ew = 0; else er = csr;
        OPC_LOAD:             er = dload;
        default: ;
      endcase
      total++; if (npc0 !== en || stall0 !== 1'b0) begin bad++; $display("FAIL result_npc[%0d] got=%h/%b want=%h/0", i, npc0, stall0, en); end
      q.push_back('{rd: er, wr: ew, chk: ew});
      step(); idle();
      pc_m = en; ir_m++;
      total++; if (ir0 !== ir_m) begin bad++; $display("FAIL result_instret[%0d] got=%0d want=%0d", i, ir0, ir_m); end
    end
  endtask

  task automatic test_misaligned();
    ce = 1; opc = oh(OPC_JALR); rs1 = 32'h203; imm = 0; #1;
    total++; if (npc0 !== 32'h202) begin bad++; $display("FAIL mis_npc got=%h want=%h", npc0, 32'h202); end
    step(); idle();
    total++; if (mis0 !== 1'b1) begin bad++; $display("FAIL mis_pulse got=%b want=1", mis0); end
    total++; if (ir0 !== ir_m || npc0 !== pc_m + 4) begin bad++; $display("FAIL mis_hold got=%0d/%h want=%0d/%h", ir0, npc0, ir_m, pc_m + 4); end
    step();
    total++; if (mis0 !== 1'b0) begin bad++; $display("FAIL mis_one_cycle got=%b want=0", mis0); end
  endtask

  task automatic test_load_wait();
    int n = 0;
    ce = 1; opc = oh(OPC_LOAD); lvalid = 0;
    for (int i = 0; i < 3; i++) begin
      #1; if (stall0 === 1'b1) n++;
      step();
    end
    lvalid = 1; dload = 32'hDEADBEEF; #1;
    if (stall0 === 1'b1) n++;
    q.push_back('{rd: 32'hDEADBEEF, wr: 1'b1, chk: 1'b1});
    step(); idle();
    pc_m = pc_m + 4; ir_m++;
    total++; if (n != 3) begin bad++; $display("FAIL load_stall_cycles got=%0d want=3", n); end
    total++; if (rd0 !== 32'hDEADBEEF) begin bad++; $display("FAIL load_rd got=%h want=deadbeef", rd0); end
    total++; if (ir0 !== ir_m) begin bad++; $display("FAIL load_instret got=%0d want=%0d", ir0, ir_m); end
    total++; if (npc0 !== pc_m + 4) begin bad++; $display("FAIL load_pc got=%h want=%h", npc0, pc_m + 4); end
  endtask

  task automatic test_flush_load();
    ce = 1; opc = oh(OPC_LOAD); lvalid = 0; step();
    total++; if (stall0 !== 1'b1) begin bad++; $display("FAIL flush_wait_entry got=%b want=1", stall0); end
    flush = 1; lvalid = 1; dload = 32'h1234; step();
    idle(); opc = oh(OPC_LOAD); #1;
    total++; if (stall0 !== 1'b0) begin bad++; $display("FAIL flush_state got stall=%b want=0", stall0); end
    total++; if (rd0 !== 32'hDEADBEEF || wr0 !== 1'b1) begin bad++; $display("FAIL flush_hold got=%h/%b want=deadbeef/1", rd0, wr0); end
    total++; if (ir0 !== ir_m || npc0 !== pc_m + 4) begin bad++; $display("FAIL flush_no_commit got=%0d/%h want=%0d/%h", ir0, npc0, ir_m, pc_m + 4); end
  endtask

  task automatic test_trap();
    ce = 1; trap = 1; mret = 1; taddr = 32'h800; raddr = 32'h40; #1;
    total++; if (npc0 !== 32'h800) begin bad++; $display("FAIL trap_npc got=%h want=800", npc0); end
    q.push_back('{rd: 0, wr: 1'b0, chk: 1'b0});
    step(); idle();
    total++; if (wr0 !== 1'b0 || ir0 !== ir_m) begin bad++; $display("FAIL trap_commit got=%b/%0d want=0/%0d", wr0, ir0, ir_m); end
    total++; if (npc0 !== 32'h804) begin bad++; $display("FAIL trap_pc got=%h want=804", npc0); end
    ce = 1; mret = 1; #1;
    q.push_back('{rd: 0, wr: 1'b0, chk: 1'b0});
    step(); idle();
    ir_m++; pc_m = 32'h40;
    total++; if (npc0 !== 32'h44 || ir0 !== ir_m) begin bad++; $display("FAIL mret got=%h/%0d want=44/%0d", npc0, ir0, ir_m); end
  endtask

  task automatic test_reset_mid_wait();
    ce = 1; opc = oh(OPC_LOAD); lvalid = 0; step();
    rst_n = 0; step(); rst_n = 1;
    idle(); opc = oh(OPC_LOAD); #1;
    pc_m = 32'h100; ir_m = 0;
    total++; if (dut0.state_q !== WB_RUN || stall0 !== 1'b0) begin bad++; $display("FAIL rst_wait_state got=%b/%b want=0/0", dut0.state_q, stall0); end
    total++; if (npc0 !== 32'h104 || ir0 !== 64'd0) begin bad++; $display("FAIL rst_wait_regs got=%h/%0d want=104/0", npc0, ir0); end
  endtask

  task automatic test_cext();
    ce = 1; comp = 1; opc = oh(OPC_JAL); imm = 32'h20; #1;
    q.push_back('{rd: 32'h104, wr: 1'b1, chk: 1'b1});
    step(); idle();
    pc_m = 32'h120; ir_m++;
    total++; if (rd1 !== 32'h102 || wr1 !== 1'b1) begin bad++; $display("FAIL cjal_rd got=%h/%b want=102/1", rd1, wr1); end
    comp = 1; #1;
    total++; if (npc1 !== 32'h122 || npc0 !== 32'h124) begin bad++; $display("FAIL cinc got=%h/%h want=122/124", npc1, npc0); end
    comp = 0; ce = 1; opc = oh(OPC_JALR); rs1 = 32'h203; imm = 0; #1;
    total++; if (npc1 !== 32'h202) begin bad++; $display("FAIL cjalr_target got=%h want=202", npc1); end
    step(); idle();
    total++; if (mis1 !== 1'b0 || rd1 !== 32'h124 || ir1 !== 2'd2) begin bad++; $display("FAIL cjalr_commit got=%b/%h/%0d want=0/124/2", mis1, rd1, ir1); end
    total++; if (npc1 !== 32'h206) begin bad++; $display("FAIL cjalr_pc got=%h want=206", npc1); end
    total++; if (mis0 !== 1'b1 || ir0 !== ir_m || npc0 !== 32'h124) begin bad++; $display("FAIL cjalr_noc got=%b/%0d/%h want=1/%0d/124", mis0, ir0, npc0, ir_m); end
  endtask

  task automatic test_back_to_back_wrap();
    ce = 1; opc = oh(OPC_ITYPE);
    for (int i = 0; i < 3; i++) begin
      alu = 32'h700 + i; #1;
      q.push_back('{rd: 32'h700 + i, wr: 1'b1, chk: 1'b1});
      step();
      ir_m++;
    end
    idle();
    total++; if (ir1 !== 2'd1) begin bad++; $display("FAIL instret_wrap got=%0d want=1", ir1); end
    total++; if (ir0 !== ir_m) begin bad++; $display("FAIL b2b_instret got=%0d want=%0d", ir0, ir_m); end
  endtask

  initial begin
    test_reset();
    test_jal();
    test_results();
    test_misaligned();
    test_load_wait();
    test_flush_load();
    test_trap();
    test_reset_mid_wait();
    test_cext();
    test_back_to_back_wrap();
    step(); step();
    total++; if (q.size() != 0) begin bad++; $display("FAIL sb_drain got=%0d want=0", q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule

// File: doc/rv_writeback_ext.md
Name: rv_writeback_ext

Overview:
- Parametrised next-generation writeback/PC-update stage for the rv32i pipeline family.
- Computes the architectural next PC and the rd writeback value/enable from decoded opcode flags, ALU, load and CSR results.
- Over the current stage it adds:
  - generic XLEN;
  - optional compressed-instruction support (PC+2);
  - a load-wait state machine that stalls on late load data;
  - flush handling;
  - misaligned-jump detection;
  - a retired-instruction counter.

Parameters:
- XLEN, 32, datapath/PC width (32 or 64).
- PC_RESET, 0, PC value after reset (XLEN bits).
- C_EXT, 0, 1 = 16-bit instructions legal: sequential increment is 2 for compressed, and targets need only halfword alignment.
- INSTRET_W, 64, width of retired-instruction counter.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_ce  in  1  stage clock enable (instruction valid in this stage)
- o_ce  out  1  registered enable to next stage
- o_stall  out  1  combinational stall request to upstream; high while waiting for load data
- i_flush  in  1  kill current instruction, no commit
- i_funct3  in  3  function field
- i_alu_out, i_imm, i_rs1, i_data_load, i_csr_out  in  XLEN each  operands
- i_load_valid  in  1  i_data_load valid this cycle
- i_compressed  in  1  current instruction is 16-bit (ignored if C_EXT=0)
- i_opcode  in  11  one-hot {fence,system,auipc,lui,jalr,jal,branch,store,load,itype,rtype}, bit0 = rtype
- i_go_to_trap, i_return_from_trap  in  1  trap entry / mret
- i_trap_address, i_return_address  in  XLEN  mtvec / mepc
- o_rd  out  XLEN  registered rd value
- o_wr_rd  out  1  registered rd write enable
- o_next_pc  out  XLEN  combinational next PC (pc_d)
- o_pc_misaligned  out  1  registered one-cycle pulse: jump/branch target misaligned
- o_instret  out  INSTRET_W  retired-instruction count

Behaviour:
- Reset: one clock, synchronous active-low reset (i_clk, i_rst_n), sampled on posedge i_clk.
  - While i_rst_n=0 at a posedge: pc=PC_RESET; o_rd=0; o_wr_rd=0; o_ce=0; o_pc_misaligned=0; o_instret=0; state=RUN.
  - Reset overrides every other input, including mid-LOAD_WAIT.
- Sequential PC:
  - inc = (C_EXT && i_compressed) ? 2 : 4.
  - pc_d defaults to pc+inc.
  - rd for jal/jalr is pc+inc.
- Priority (highest first): i_flush > i_go_to_trap > i_return_from_trap > normal.
- Trap entry:
  - pc_d = i_trap_address; wr_rd_d = 0; no retire.
- mret:
  - pc_d = i_return_address; wr_rd_d = 0; retires.
- Normal results:
  - rtype/itype: rd = alu.
  - load: rd = i_data_load.
  - lui: rd = imm.
  - auipc: rd = pc+imm.
  - system with funct3≠0: rd = csr.
- Normal control flow:
  - branch: pc_d = pc+imm if alu[0].
  - jal: pc_d = pc+imm.
  - jalr: pc_d = (rs1+imm) & ~1.
  - One shared adder serves all of these.
- Writeback enable:
  - wr_rd_d = 1 except for branch, store, fence, and system with funct3=0.
- Misalignment:
  - Applies to a taken branch, jal or jalr whose target has bit1=1 while C_EXT=0.
  - Instruction does not commit: pc, o_rd, o_wr_rd and o_instret are held.
  - o_pc_misaligned=1 for exactly the next cycle.
  - pc_d (o_next_pc) still shows the offending target so the trap unit can latch mtval.
- State machine:
  - RUN:
    - If i_ce && !i_flush && load && !i_load_valid: go to LOAD_WAIT with o_stall=1; no register update; o_ce=0.
    - Otherwise commit on i_ce: pc/o_rd/o_wr_rd update and o_ce=i_ce.
  - LOAD_WAIT:
    - o_stall=1; instruction operands are held stable by upstream.
    - On i_load_valid: commit using i_data_load, drop o_stall that same cycle, o_ce=1 next cycle, return to RUN.
    - On i_flush: return to RUN with no commit.
    - Flush wins over a simultaneous i_load_valid.
  - A same-cycle load with i_load_valid=1 in RUN commits with no stall.
- Flush: no update of pc/o_rd/o_wr_rd/o_instret; o_ce=0 next cycle.
- When i_ce=0, all architectural registers hold; o_ce follows i_ce.
- o_instret:
  - +1 per committed instruction (including mret), not for trap entry, flush, or misaligned.
  - Wraps modulo 2^INSTRET_W.

Decomposition:
- Shared package rv_pkg holds:
  - opcode one-hot index constants (OPC_RTYPE=0 … OPC_FENCE=10);
  - funct3 constants;
  - state encoding (WB_RUN, WB_LOAD_WAIT);
  - XLEN default.
- One sub-module, rv_next_pc: combinational shared adder, target selection and alignment check. Keeps the top to state machine plus registers.

Test Plan:
- Reset with PC_RESET=0x100 → next cycle pc=0x100, o_next_pc=0x104, o_instret=0; hold reset mid-LOAD_WAIT → state RUN, o_stall=0.
- jal with pc=0x100, imm=0x20 → o_rd=0x104, o_wr_rd=1, pc=0x120; C_EXT=1 with compressed jal → o_rd=0x102.
- jalr with rs1=0x203, imm=0 → target 0x202. With C_EXT=0: o_pc_misaligned pulses 1 cycle and pc/o_instret unchanged. With C_EXT=1: commits with pc=0x202.
- Load with i_load_valid low for 3 cycles then data 0xDEADBEEF → o_stall high exactly 3 cycles, o_rd=0xDEADBEEF, o_instret +1 once.
- i_flush together with i_load_valid in LOAD_WAIT → no commit, o_wr_rd unchanged, state RUN.
- i_go_to_trap with i_return_from_trap, mtvec=0x800 → pc=0x800, o_wr_rd=0, o_instret unchanged; mret alone with mepc=0x40 → pc=0x40, o_instret +1.
